// File: rtl/rc4_ksa_sequencer_if.sv
// Start/done handshake plus S-memory port between the KSA sequencer (master) and its environment (slave).
interface rc4_ksa_sequencer_if #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
);
  logic                   start;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic                   busy;
  logic                   done;
  logic [ADDR_W-1:0]      s_addr;
  logic [7:0]             s_wrdata;
  logic                   s_wren;
  logic [7:0]             s_rddata;

  modport master (
    input  start, secret_key, s_rddata,
    output busy, done, s_addr, s_wrdata, s_wren
  );

  modport slave (
    output start, secret_key, s_rddata,
    input  busy, done, s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/rc4_ksa_sequencer.sv
// RC4 key scheduling over a 256-byte S memory: 7 cycles per swap, plus 256 identity writes when KSA_INIT_EN is defined.
// Start is only honoured in IDLE (never queued); outputs decode from registered state, memory read latency is one cycle.
module rc4_ksa_sequencer #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rc4_ksa_sequencer_if.master bus
);
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [ADDR_W-1:0] I_LAST    = {ADDR_W{1'b1}};

  typedef enum logic [3:0] {
    IDLE, INIT, RD_SI, CAP_SI, CALC_J, RD_SJ, CAP_SJ, WR_SI, WR_SJ, DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      i, j;
  logic [KIDX_W-1:0]      kidx;
  logic [7:0]             si, sj;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             key_byte;

  assign key_byte = key_q[8*int'(kidx) +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      si    <= '0;
      sj    <= '0;
      key_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          key_q <= bus.secret_key;
          i     <= '0;
          j     <= '0;
          kidx  <= '0;
        end
        // i wraps to zero on its own after the last identity write
        INIT:   i  <= i + ADDR_W'(1);
        CAP_SI: si <= bus.s_rddata;
        CALC_J: j  <= j + ADDR_W'(si) + ADDR_W'(key_byte);
        CAP_SJ: sj <= bus.s_rddata;
        WR_SJ: begin
          i    <= i + ADDR_W'(1);
          kidx <= (kidx == KIDX_LAST) ? '0 : kidx + KIDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef KSA_INIT_EN
      IDLE:   if (bus.start) state_nxt = INIT;
`else
      IDLE:   if (bus.start) state_nxt = RD_SI;
`endif
      INIT:   if (i == I_LAST) state_nxt = RD_SI;
      RD_SI:  state_nxt = CAP_SI;
      CAP_SI: state_nxt = CALC_J;
      CALC_J: state_nxt = RD_SJ;
      RD_SJ:  state_nxt = CAP_SJ;
      CAP_SJ: state_nxt = WR_SI;
      WR_SI:  state_nxt = WR_SJ;
      WR_SJ:  state_nxt = (i == I_LAST) ? DONE : RD_SI;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.s_addr   = '0;
    bus.s_wrdata = '0;
    bus.s_wren   = 1'b0;
    case (state)
      INIT: begin
        bus.busy     = 1'b1;
        bus.s_addr   = i;
        bus.s_wrdata = 8'(i);
        bus.s_wren   = 1'b1;
      end
      RD_SI, CAP_SI, CALC_J: begin
        bus.busy   = 1'b1;
        bus.s_addr = i;
      end
      RD_SJ, CAP_SJ: begin
        bus.busy   = 1'b1;
        bus.s_addr = j;
      end
      // when i == j both writes hit one address and the last one restores S[i]
      WR_SI: begin
        bus.busy     = 1'b1;
        bus.s_addr   = i;
        bus.s_wrdata = sj;
        bus.s_wren   = 1'b1;
      end
      WR_SJ: begin
        bus.busy     = 1'b1;
        bus.s_addr   = j;
        bus.s_wrdata = si;
        bus.s_wren   = 1'b1;
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rc4_ksa_sequencer.sv
// Directed bench for rc4_ksa_sequencer with a one-cycle-latency S memory and a behavioural KSA model.
module tb_rc4_ksa_sequencer;
  localparam int KEY_BYTES = 3;
  localparam int ADDR_W    = 8;
`ifdef KSA_INIT_EN
  localparam int INIT_CYC = 256;
`else
  localparam int INIT_CYC = 0;
`endif
  // Cycle offsets relative to the cycle in which start is sampled high
  localparam int FIRST_SWAP_WR = INIT_CYC + 6;
  localparam int DONE_OFS      = INIT_CYC + 1793;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rc4_ksa_sequencer_if #(.KEY_BYTES(KEY_BYTES), .ADDR_W(ADDR_W)) bus ();

  rc4_ksa_sequencer #(.KEY_BYTES(KEY_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem   [256];
  logic [7:0] exp_s [256];
  int         pre_mode = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         wr_cyc [$];
  logic [7:0] wr_addr [$];
  logic [7:0] wr_dat [$];
  int         done_cyc [$];

  // S memory: synchronous write, registered read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_mode != 0) begin
      for (int k = 0; k < 256; k++) mem[k] <= (pre_mode == 1) ? 8'(k) : ~8'(k);
    end else if (bus.s_wren) begin
      mem[bus.s_addr] <= bus.s_wrdata;
    end
    bus.s_rddata <= mem[bus.s_addr];
  end

  always @(negedge clk) begin
    if (bus.s_wren) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(bus.s_addr);
      wr_dat.push_back(bus.s_wrdata);
    end
    if (bus.done) done_cyc.push_back(cyc);
  end

  task automatic clear_log();
    wr_cyc.delete();
    wr_addr.delete();
    wr_dat.delete();
    done_cyc.delete();
  endtask

  task automatic preload(input bit identity);
    @(negedge clk);
    pre_mode = identity ? 1 : 2;
    @(negedge clk);
    pre_mode = 0;
  endtask

  task automatic model_ksa(input logic [23:0] key);
    int jj;
    logic [7:0] t;
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    jj = 0;
    for (int k = 0; k < 256; k++) begin
      jj = (jj + int'(exp_s[k]) + int'(key[8*(k%KEY_BYTES) +: 8])) % 256;
      t = exp_s[k];
      exp_s[k] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic pulse_start(input logic [23:0] key, output int sc);
    @(negedge clk);
    bus.secret_key = key;
    bus.start = 1'b1;
    sc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int n;
    n = 0;
    while (done_cyc.size() == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (done_cyc.size() != 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0)   begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.s_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren got %b want 0", bus.s_wren); end
    n_cmp++; if (bus.s_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr got %h want 00", bus.s_addr); end
    n_cmp++; if (bus.s_wrdata !== 8'h00) begin n_bad++; $display("FAIL reset_wrdata got %h want 00", bus.s_wrdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  // Key 0: INIT writes, first swap (j=0, S[0]=0 twice), second swap (j=1, S[1]=1 twice)
  task automatic test_first_iterations();
    int sc, bad;
    bit ok;
`ifdef KSA_INIT_EN
    preload(1'b0);
`else
    preload(1'b1);
`endif
    model_ksa(24'h000000);
    clear_log();
    pulse_start(24'h000000, sc);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start got %b want 1", bus.busy); end
    wait_done(DONE_OFS + 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL done_timeout_k0 got no done want done"); end
    n_cmp++; if (wr_cyc.size() != INIT_CYC + 512) begin n_bad++; $display("FAIL write_count_k0 got %0d want %0d", wr_cyc.size(), INIT_CYC + 512); end
`ifdef KSA_INIT_EN
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (wr_addr[k] !== 8'(k) || wr_dat[k] !== 8'(k) || wr_cyc[k] != sc + 1 + k) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL init_writes got %0d bad entries want 0", bad); end
`endif
    n_cmp++; if (wr_cyc[INIT_CYC] != sc + FIRST_SWAP_WR) begin n_bad++; $display("FAIL first_swap_time got %0d want %0d", wr_cyc[INIT_CYC] - sc, FIRST_SWAP_WR); end
    n_cmp++; if ({wr_addr[INIT_CYC], wr_dat[INIT_CYC], wr_addr[INIT_CYC+1], wr_dat[INIT_CYC+1]} !== 32'h00000000)
      begin n_bad++; $display("FAIL swap0_writes got %h/%h %h/%h want 00/00 00/00", wr_addr[INIT_CYC], wr_dat[INIT_CYC], wr_addr[INIT_CYC+1], wr_dat[INIT_CYC+1]); end
    n_cmp++; if ({wr_addr[INIT_CYC+2], wr_dat[INIT_CYC+2], wr_addr[INIT_CYC+3], wr_dat[INIT_CYC+3]} !== 32'h01010101)
      begin n_bad++; $display("FAIL swap1_same_addr got %h/%h %h/%h want 01/01 01/01", wr_addr[INIT_CYC+2], wr_dat[INIT_CYC+2], wr_addr[INIT_CYC+3], wr_dat[INIT_CYC+3]); end
    n_cmp++; if (wr_cyc[INIT_CYC+2] != sc + FIRST_SWAP_WR + 7) begin n_bad++; $display("FAIL swap_period got %0d want %0d", wr_cyc[INIT_CYC+2] - sc, FIRST_SWAP_WR + 7); end
    n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != sc + DONE_OFS) begin n_bad++; $display("FAIL done_k0 got count %0d at %0d want 1 at %0d", done_cyc.size(), done_cyc[0] - sc, DONE_OFS); end
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL final_s_k0 got %0d differing bytes want 0", bad); end
  endtask

  // Key 0x00033C full run with a second start pulse (different key) mid-shuffle
  task automatic test_start_ignored();
    int sc, bad;
    bit ok;
    preload(1'b1);
    model_ksa(24'h00033C);
    clear_log();
    pulse_start(24'h00033C, sc);
    while (cyc < sc + INIT_CYC + 300) @(negedge clk);
    bus.secret_key = 24'hFFFFFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid_run got %b want 1", bus.busy); end
    wait_done(DONE_OFS + 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL done_timeout_key got no done want done"); end
    n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != sc + DONE_OFS) begin n_bad++; $display("FAIL done_key got count %0d at %0d want 1 at %0d", done_cyc.size(), done_cyc[0] - sc, DONE_OFS); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_done got %b want 0", bus.busy); end
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL final_s_key got %0d differing bytes want 0", bad); end
  endtask

  // Asynchronous reset during swap 100, then a clean re-run
  task automatic test_reset_mid_run();
    int sc, bad;
    bit ok;
    preload(1'b1);
    model_ksa(24'h00033C);
    clear_log();
    pulse_start(24'h00033C, sc);
    while (cyc < sc + INIT_CYC + 100*7 + 6) @(negedge clk);
    n_cmp++; if (bus.s_wren !== 1'b1) begin n_bad++; $display("FAIL wren_in_wr_si got %b want 1", bus.s_wren); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.s_wren, bus.s_addr, bus.s_wrdata} !== 19'h0)
      begin n_bad++; $display("FAIL async_reset got busy=%b done=%b wren=%b addr=%h wd=%h want all 0", bus.busy, bus.done, bus.s_wren, bus.s_addr, bus.s_wrdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifndef KSA_INIT_EN
    preload(1'b1);
`endif
    clear_log();
    pulse_start(24'h00033C, sc);
    wait_done(DONE_OFS + 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL done_timeout_rerun got no done want done"); end
`ifdef KSA_INIT_EN
    n_cmp++; if (wr_cyc[0] != sc + 1 || wr_addr[0] !== 8'h00 || wr_dat[0] !== 8'h00)
      begin n_bad++; $display("FAIL rerun_first_write got @%0d %h/%h want @1 00/00", wr_cyc[0] - sc, wr_addr[0], wr_dat[0]); end
`else
    n_cmp++; if (wr_cyc[0] != sc + 6 || wr_addr[0] !== 8'h00 || wr_dat[0] !== 8'h3C)
      begin n_bad++; $display("FAIL rerun_first_write got @%0d %h/%h want @6 00/3c", wr_cyc[0] - sc, wr_addr[0], wr_dat[0]); end
`endif
    n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != sc + DONE_OFS) begin n_bad++; $display("FAIL done_rerun got count %0d at %0d want 1 at %0d", done_cyc.size(), done_cyc[0] - sc, DONE_OFS); end
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL final_s_rerun got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.secret_key = '0;
    test_reset();
    test_first_iterations();
    test_start_ignored();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
